mips_bus_sequencer: RTL
=======================

// Module: mips_bus_sequencer
// PURPOSE
//  Multi-cycle sequencer that shares one Avalon-style memory bus between instruction fetch and data access.
//  Sits between the CPU top level and the single-cycle datapath.
//  Latches the fetched instruction and loaded data so the datapath sees them stable.
//  Pulses the datapath clock enable once per instruction; detects halt (fetch from 0x00000000) and drives active.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max consecutive waitrequest cycles before bus_error (only with WAIT_TIMEOUT_EN)
// PORTS
//  clk              in   1   system clock; all state on posedge
//  reset            in   1   synchronous, active-high
//  clk_enable       in   1   global enable; low freezes FSM, latches and bus outputs
//  active           out  1   high while CPU running; low after halt or during reset
//  bus_address      out  32  word address to memory
//  bus_read         out  1   read strobe
//  bus_write        out  1   write strobe
//  bus_byteenable   out  4   byte lanes; 4'hF for fetch, dp_byteenable for data
//  bus_writedata    out  32  store data
//  bus_readdata     in   32  memory read data
//  bus_waitrequest  in   1   memory stall; transfer completes in a cycle it is low
//  dp_instr_address in   32  datapath PC
//  dp_data_address  in   32  datapath ALU result (load/store address)
//  dp_writedata     in   32  datapath store data
//  dp_byteenable    in   4   lanes for current load/store
//  dp_mem_read      in   1   current instruction is a load (decoded from latched instr)
//  dp_mem_write     in   1   current instruction is a store
//  dp_instr         out  32  latched instruction (instr register) to datapath/decoder
//  dp_readdata      out  32  latched load data to datapath
//  dp_step          out  1   one-cycle clock enable to datapath PC/regfile
//  bus_error        out  1   sticky timeout flag (only with WAIT_TIMEOUT_EN)
// BEHAVIOUR
//  States: RST -> FETCH -> EXEC -> [MEM] -> COMMIT -> FETCH; HALT is terminal until reset.
//  Reset (sync): state=RST, dp_instr=0, dp_readdata=0, active=0, bus_read=bus_write=0, dp_step=0, bus_error=0.
//  Reset mid-transfer drops strobes in the cycle after the sampling edge.
//  RST: strobes low for one cycle; active=1 from the next edge; -> FETCH.
//  FETCH entry: if dp_instr_address==0 -> HALT (no read issued), active=0 from that edge.
//  FETCH otherwise: bus_read=1, bus_address=dp_instr_address, byteenable=4'hF.
//    Address/strobes are held stable while waitrequest=1.
//    On waitrequest=0: dp_instr<=bus_readdata; -> EXEC.
//  EXEC: one settle cycle, no strobes; dp_mem_read -> MEM(read), dp_mem_write -> MEM(write), else -> COMMIT.
//    Both set: read wins.
//  MEM read: bus_read=1, address=dp_data_address, byteenable=dp_byteenable.
//    On waitrequest=0: dp_readdata<=bus_readdata; -> COMMIT.
//  MEM write: bus_write=1, bus_writedata=dp_writedata, same address/byteenable.
//    On waitrequest=0 -> COMMIT.
//  bus_read and bus_write are never high together. Outside FETCH/MEM, address/writedata are don't-care and strobes are 0.
//  COMMIT: dp_step=1 for exactly one cycle; -> FETCH.
//  Minimum latency: 4 cycles (ALU op), 5 cycles (load/store), with zero wait states.
//  HALT: strobes 0, dp_step 0, active 0; only reset exits.
//  clk_enable=0: no state/latch change; strobes hold their current values; dp_step forced 0.
//    dp_step re-asserts on resume if still in COMMIT.
// CONFIGURATION
//  WAIT_TIMEOUT_EN defined:
//    8+ bit counter clears on every state change and counts cycles with waitrequest=1 in FETCH/MEM.
//    Reaching TIMEOUT_CYCLES sets bus_error=1 (sticky), drops strobes and -> HALT.
//  WAIT_TIMEOUT_EN undefined: no counter; bus_error tied 0; waits indefinitely.
// TESTING
//  1. Reset with dp_instr_address=32'hBFC00000, waitrequest=0, instr=ADDIU:
//     read at BFC00000 one cycle after RST; dp_step pulse 3 cycles later; active=1.
//  2. Fetch with waitrequest high 3 cycles:
//     address/read stable all 4 cycles; dp_instr latched only on the low cycle.
//  3. Load, dp_data_address=32'h00001004, dp_byteenable=4'b0011, readdata=32'hDEADBEEF:
//     MEM read with byteenable 0011; dp_readdata=DEADBEEF before dp_step.
//  4. Store, dp_writedata=32'h12345678: bus_write=1 with data; bus_read=0 throughout; dp_step one cycle after accept.
//  5. dp_instr_address=0 at FETCH: no read strobe; active falls and stays 0; dp_step never pulses.
//  6. WAIT_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck 1: bus_error=1 after 4 wait cycles, strobes low, active=0.
//     Mid-MEM reset clears all of it.

Source files
------------

// File: rtl/mips_bus_sequencer.sv
// mips_bus_sequencer: FETCH/EXEC/MEM/COMMIT sequencer sharing one Avalon bus between fetch and data access.
module mips_bus_sequencer #(parameter int TIMEOUT_CYCLES = 256) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  output logic        active,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata,
  input  logic [31:0] bus_readdata,
  input  logic        bus_waitrequest,
  input  logic [31:0] dp_instr_address,
  input  logic [31:0] dp_data_address,
  input  logic [31:0] dp_writedata,
  input  logic [3:0]  dp_byteenable,
  input  logic        dp_mem_read,
  input  logic        dp_mem_write,
  output logic [31:0] dp_instr,
  output logic [31:0] dp_readdata,
  output logic        dp_step,
  output logic        bus_error
);
  typedef enum logic [2:0] {RST, FETCH, EXEC, MEM, COMMIT, HALT} state_t;
  state_t state_q, state_d;
  logic active_q, active_d, rd_q, rd_d, wr_q, wr_d, step_q, step_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, instr_q, instr_d, rdata_q, rdata_d;
  logic [3:0] be_q, be_d;
`ifdef WAIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) < 8 ? 8 : $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, expire;
`endif
  always_comb begin
    state_d = state_q;
    active_d = active_q;
    rd_d = rd_q;
    wr_d = wr_q;
    addr_d = addr_q;
    be_d = be_q;
    wdata_d = wdata_q;
    instr_d = instr_q;
    rdata_d = rdata_q;
    step_d = 1'b0;
    case (state_q)
      RST: begin
        state_d = FETCH;
        active_d = 1'b1;
      end
      FETCH:
        if (!rd_q) begin
          if (dp_instr_address == '0) begin
            state_d = HALT;
            active_d = 1'b0;
          end else begin
            rd_d = 1'b1;
            addr_d = dp_instr_address;
            be_d = 4'hF;
          end
        end else if (!bus_waitrequest) begin
          instr_d = bus_readdata;
          rd_d = 1'b0;
          state_d = EXEC;
        end
      EXEC: begin
        state_d = (dp_mem_read || dp_mem_write) ? MEM : COMMIT;
        rd_d = dp_mem_read;
        wr_d = dp_mem_write && !dp_mem_read;
        addr_d = dp_data_address;
        be_d = dp_byteenable;
        wdata_d = dp_writedata;
        step_d = !(dp_mem_read || dp_mem_write);
      end
      MEM:
        if (!bus_waitrequest) begin
          rdata_d = rd_q ? bus_readdata : rdata_q;
          rd_d = 1'b0;
          wr_d = 1'b0;
          step_d = 1'b1;
          state_d = COMMIT;
        end
      COMMIT: state_d = FETCH;
      default: begin
        rd_d = 1'b0;
        wr_d = 1'b0;
        active_d = 1'b0;
      end
    endcase
`ifdef WAIT_TIMEOUT_EN
    expire = (rd_q || wr_q) && bus_waitrequest && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    err_d = err_q || expire;
    if (expire) begin
      state_d = HALT;
      rd_d = 1'b0;
      wr_d = 1'b0;
      active_d = 1'b0;
      step_d = 1'b0;
    end
    cnt_d = (state_d != state_q) ? '0 : ((rd_q || wr_q) && bus_waitrequest) ? cnt_q + CW'(1) : cnt_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RST;
      active_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      step_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      instr_q <= '0;
      rdata_q <= '0;
    end else if (clk_enable) begin
      state_q <= state_d;
      active_q <= active_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      step_q <= step_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      instr_q <= instr_d;
      rdata_q <= rdata_d;
    end
  end
`ifdef WAIT_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (clk_enable) begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus_error = err_q;
`else
  assign bus_error = 1'b0;
`endif
  assign active = active_q;
  assign bus_address = addr_q;
  assign bus_read = rd_q;
  assign bus_write = wr_q;
  assign bus_byteenable = be_q;
  assign bus_writedata = wdata_q;
  assign dp_instr = instr_q;
  assign dp_readdata = rdata_q;
  assign dp_step = step_q && clk_enable;
endmodule
